fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the single-cycle, zero-latency PC/instruction path of the first-generation core. It issues sequential fetch requests to a variable-latency instruction memory with up to DEPTH requests in flight, and buffers returned instructions in a DEPTH-entry queue. Decode consumes from the queue through a valid/ready handshake; redirects from EX/MEM flush the queue and drop stale responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 85 ++++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  // Width of one RV32 instruction word.
  localparam int INSTR_W = 32;

  // Canonical RV32 NOP (addi x0, x0, 0), shown on the queue head when empty.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Sequential successor of a fetch address. Callers truncate the result to
  // their own PC width, which gives wrap-around modulo 2^XLEN.
  function automatic logic [63:0] next_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO for fetched {pc, instr} entries. Slot 0 is always the
// head, so the head data and valid flag come straight from flops. Unused
// slots hold EMPTY_VAL, which makes the head read EMPTY_VAL when empty.
// A flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int              WIDTH     = 64,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem     [DEPTH];
  logic [WIDTH-1:0] w_mem_nxt [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_cnt_pop;
  logic [CW-1:0]    w_count_nxt;
  logic             r_valid;

  // Next-state of the storage: flush, else shift on pop, then write on push.
  always_comb begin
    w_cnt_pop   = r_count;
    w_count_nxt = r_count;
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = r_mem[i];
    end
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_mem_nxt[i] = EMPTY_VAL;
      end
      w_cnt_pop   = '0;
      w_count_nxt = '0;
    end else begin
      if (i_pop && (r_count != '0)) begin
        for (int i = 0; i < DEPTH-1; i++) begin
          w_mem_nxt[i] = r_mem[i+1];
        end
        w_mem_nxt[DEPTH-1] = EMPTY_VAL;
        w_cnt_pop          = r_count - CW'(1);
      end else begin
        w_cnt_pop = r_count;
      end
      if (i_push && (w_cnt_pop < CW'(DEPTH))) begin
        for (int i = 0; i < DEPTH; i++) begin
          w_mem_nxt[i] = (CW'(i) == w_cnt_pop) ? i_data : w_mem_nxt[i];
        end
        w_count_nxt = w_cnt_pop + CW'(1);
      end else begin
        w_count_nxt = w_cnt_pop;
      end
    end
  end

  // Storage, occupancy and head-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= EMPTY_VAL;
      end
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_data      = r_mem[0];
  assign o_valid     = r_valid;
  assign o_occupancy = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues sequential requests to a
// variable-latency, in-order instruction memory, tracks requests in flight,
// drops responses made stale by a redirect, and queues the rest for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int             CW          = $clog2(DEPTH+1);
  localparam int             EW          = XLEN + INSTR_W;
  localparam logic [CW:0]    DEPTH_SUM   = (CW+1)'(DEPTH);
  localparam logic [EW-1:0]  EMPTY_ENTRY = {{XLEN{1'b0}}, NOP_INSTR};

  // PC successor at this unit's width; the truncation provides the wrap.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return XLEN'(next_pc(64'(pc)));
  endfunction

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] w_resp_pc_nxt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [XLEN-1:0] w_redirect_base;
  logic [CW-1:0]   w_occupancy;
  logic [CW:0]     w_inflight;
  logic            w_room;
  logic            w_grant;
  logic            w_resp_live;
  logic            w_push;
  logic            w_pop;
  logic            w_out_valid;
  logic [EW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;

  // Queue slots plus requests in flight never exceed DEPTH, so every
  // response already has a reserved queue slot when it arrives.
  assign w_inflight  = {1'b0, w_occupancy} + {1'b0, r_outstanding};
  assign w_room      = (w_inflight < DEPTH_SUM);
  assign imem_req    = !rst && !redirect_valid && w_room;
  assign w_grant     = imem_req && imem_gnt;

  // A response with nothing outstanding is a leftover from before reset.
  assign w_resp_live = imem_rvalid && (r_outstanding != '0);

  assign w_redirect_base = redirect_pc & ~XLEN'(3);
  assign w_push_data     = {r_resp_pc, imem_rdata};
  assign w_pop           = w_out_valid && out_ready;

  // Next values of PCs and in-flight counters; a redirect overrides all.
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = r_outstanding;
    w_discard_nxt     = r_discard;
    w_push            = 1'b0;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_fetch_pc_nxt    = w_redirect_base;
      w_resp_pc_nxt     = w_redirect_base;
      w_outstanding_nxt = r_outstanding - CW'(w_resp_live);
      w_discard_nxt     = r_outstanding - CW'(w_resp_live);
    end else begin
      w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_resp_live);
      if (w_grant) begin
        w_fetch_pc_nxt = pc_inc(r_fetch_pc);
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
      end
      if (w_resp_live) begin
        if (r_discard != '0) begin
          w_discard_nxt = r_discard - CW'(1);
        end else begin
          w_push        = 1'b1;
          w_resp_pc_nxt = pc_inc(r_resp_pc);
        end
      end else begin
        w_discard_nxt = r_discard;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH     (EW),
    .DEPTH     (DEPTH),
    .EMPTY_VAL (EMPTY_ENTRY)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .i_data      (w_push_data),
    .o_data      (w_head),
    .o_valid     (w_out_valid),
    .o_occupancy (w_occupancy)
  );

  assign imem_addr = r_fetch_pc;
  assign out_valid = w_out_valid;
  assign out_pc    = w_head[EW-1:INSTR_W];
  assign out_instr = w_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model with
// programmable latency, directed phases, and a scoreboard of expected
// {pc, instr} entries popped by a monitor on every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t pend[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    lat      = 1;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{pc: base + 32'(4*k), instr: instr_of(base + 32'(4*k))});
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Instruction memory: in-order responses lat cycles after grant.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      @(negedge clk);
      if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, due: cyc + lat});
    end
  end

  // Monitor: every valid handshake outside reset/redirect consumes one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready && !redirect_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed phases.
  initial begin
    int found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", out_valid, 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0000_0013);

    // Zero-wait memory, decode always ready.
    tick(); rst = 1'b0; imem_gnt = 1'b1; out_ready = 1'b1; push_exp(32'h0, 20);
    @(negedge clk);
    check("p1_first_req", imem_req, 32'd1);
    check("p1_first_addr", imem_addr, 32'h0);
    tick(); @(negedge clk);
    check("p1_startup_valid", out_valid, 32'd0);
    tick(); @(negedge clk);
    check("p1_first_valid", out_valid, 32'd1);
    check("p1_first_pc", out_pc, 32'h0);
    for (int k = 3; k < 10; k++) begin
      tick(); @(negedge clk);
      check("p1_stream_valid", out_valid, 32'd1);
    end
    wait_drain("p1_drain", 40);

    // Latency-3 memory after an idle drain; redirect LSBs must be ignored.
    tick(); imem_gnt = 1'b0; lat = 3;
    repeat (6) tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; imem_gnt = 1'b1;
    exp_q.delete(); push_exp(32'h200, 64);
    @(negedge clk);
    check("p2_redirect_req", imem_req, 32'd0);
    tick(); redirect_valid = 1'b0; @(negedge clk);
    check("p2_req_n1", imem_req, 32'd1);
    check("p2_addr_n1", imem_addr, 32'h200);
    check("p2_valid_n1", out_valid, 32'd0);
    tick(); tick(); tick(); @(negedge clk);
    check("p2_req_n4", imem_req, 32'd1);
    check("p2_addr_n4", imem_addr, 32'h20C);
    tick(); @(negedge clk);
    check("p2_req_full", imem_req, 32'd0);
    check("p2_valid_n5", out_valid, 32'd1);
    check("p2_pc_n5", out_pc, 32'h200);
    repeat (6) tick();

    // Decode stall for 10 cycles: queue fills, requests stop.
    for (int k = 1; k <= 10; k++) begin
      tick(); out_ready = 1'b0; @(negedge clk);
      if (k >= 5) check("p3_req_stall", imem_req, 32'd0);
    end
    check("p3_valid_stall", out_valid, 32'd1);

    // Release two entries, stall, then redirect with 2 outstanding, 2 queued.
    tick(); out_ready = 1'b1;
    tick();
    tick(); out_ready = 1'b0;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    exp_q.delete(); push_exp(32'h100, 64);
    @(negedge clk);
    check("p4_redirect_req", imem_req, 32'd0);
    tick(); redirect_valid = 1'b0; out_ready = 1'b1; @(negedge clk);
    check("p4_req_n1", imem_req, 32'd1);
    check("p4_addr_n1", imem_addr, 32'h100);
    check("p4_valid_n1", out_valid, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      tick(); @(negedge clk);
      check("p4_valid_gap", out_valid, 32'd0);
    end
    tick(); @(negedge clk);
    check("p4_valid_n5", out_valid, 32'd1);
    check("p4_pc_n5", out_pc, 32'h100);
    check("p4_instr_n5", out_instr, 32'hDEAD_0100);

    // Redirect in a cycle with both a response and a decode handshake.
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(posedge clk); #2;
      if (imem_rvalid && out_valid) found = 1;
    end
    check("p5_found_cycle", 32'(found), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    exp_q.delete(); push_exp(32'h300, 64);
    @(negedge clk);
    check("p5_redirect_req", imem_req, 32'd0);
    tick(); redirect_valid = 1'b0; @(negedge clk);
    check("p5_valid_n1", out_valid, 32'd0);
    repeat (12) tick();

    // Reset with 3 requests in flight; their late responses must be ignored.
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(posedge clk); #2;
      if (pend.size() + (imem_rvalid ? 1 : 0) == 3) found = 1;
    end
    check("p6_found_cycle", 32'(found), 32'd1);
    rst = 1'b1; imem_gnt = 1'b0; exp_q.delete();
    @(negedge clk);
    check("p6_rst_req", imem_req, 32'd0);
    check("p6_rst_valid", out_valid, 32'd0);
    check("p6_rst_addr", imem_addr, 32'h0);
    check("p6_rst_instr", out_instr, 32'h0000_0013);
    tick(); rst = 1'b0; @(negedge clk);
    check("p6_restart_req", imem_req, 32'd1);
    check("p6_restart_addr", imem_addr, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick(); @(negedge clk);
      check("p6_late_ignored", out_valid, 32'd0);
    end
    tick(); lat = 1; imem_gnt = 1'b1; push_exp(32'h0, 12);
    wait_drain("p6_drain", 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
